wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, stall cycles before watchdog error (range 2..65535).
REQ-002 Ports, one clock, reset asynchronous active-low; N = 0,1 denotes one line per master port:
 clk_i  in  1  system clock
 rst_n  in  1  asynchronous active-low reset
 mN_wb_cyc_i  in  1  master N cycle
 mN_wb_stb_i  in  1  master N strobe
 mN_wb_we_i  in  1  master N write enable
 mN_wb_sel_i  in  4  master N byte select
 mN_wb_adr_i  in  32  master N address
 mN_wb_dat_i  in  32  master N write data
 mN_wb_dat_o  out  32  master N read data
 mN_wb_ack_o  out  1  master N acknowledge
 mN_wb_err_o  out  1  master N error
 s_wb_cyc_o  out  1  shared bus cycle, to interconnect master port
 s_wb_stb_o  out  1  shared bus strobe
 s_wb_we_o  out  1  shared bus write enable
 s_wb_sel_o  out  4  shared bus byte select
 s_wb_adr_o  out  32  shared bus address
 s_wb_dat_o  out  32  shared bus write data
 s_wb_dat_i  in  32  shared bus read data
 s_wb_ack_i  in  1  shared bus acknowledge
 s_wb_err_i  in  1  shared bus error

Function
REQ-003 FSM states IDLE, GNT0, GNT1; state and a 1-bit last_owner register are clocked on clk_i rising edge.
REQ-004 IDLE: one request (mN_wb_cyc_i=1) -> GNTN next cycle; both requesting -> grant master != last_owner; none -> stay IDLE.
REQ-005 Entering GNTN, last_owner shall be set to N.
REQ-006 GNTN: s_wb_* outputs combinationally equal master N inputs; in IDLE s_wb_cyc_o=s_wb_stb_o=s_wb_we_o=0, s_wb_sel_o/adr_o/dat_o=0.
REQ-007 GNTN: mN_wb_ack_o=s_wb_ack_i, mN_wb_dat_o=s_wb_dat_i, mN_wb_err_o=s_wb_err_i (plus REQ-013); the non-owner's ack/err/dat_o shall be 0.
REQ-008 GNTN -> IDLE on the cycle after mN_wb_cyc_i is sampled 0; no direct GNT0<->GNT1 transition (minimum one IDLE cycle between owners).
REQ-009 Grant is held for the full cyc_i assertion including multi-beat/locked sequences; no preemption.
REQ-010 Acks arriving in IDLE or for a master whose cyc_i is low shall be discarded.
REQ-011 Arbitration latency: request in IDLE -> s_wb_cyc_o high exactly 1 cycle later.

Reset
REQ-012 rst_n low: state=IDLE, last_owner=1 (m0 wins first contention), timeout counter=0, all outputs 0 immediately, including mid-transfer; no transfer resumes after reset release.

Configuration
REQ-013 Macro WB_ARB_TIMEOUT_EN defined: 16-bit counter increments each GNTN cycle with s_wb_stb_o=1 and s_wb_ack_i=s_wb_err_i=0, clears on ack/err/IDLE; when count reaches TIMEOUT_CYC-1, mN_wb_err_o pulses 1 cycle, s_wb_stb_o forced 0 that cycle, counter clears.
REQ-014 Macro undefined: no counter logic; mN_wb_err_o passes s_wb_err_i only; a hung slave stalls the owner indefinitely.

Verification
REQ-015 Single request: m1 cyc/stb, adr=0x0000_1004, we=1, dat=0xA5A5_0001 -> s_wb_cyc_o high 1 cycle later with identical adr/dat; s_wb_ack_i -> m1_wb_ack_o=1, m0_wb_ack_o=0.
REQ-016 Contention after reset: m0, m1 assert same cycle -> GNT0; m0 drops cyc -> IDLE 1 cycle -> GNT1; repeat -> GNT0 (strict alternation over 8 rounds).
REQ-017 Read routing: GNT0, s_wb_dat_i=0xDEAD_BEEF with ack -> m0_wb_dat_o=0xDEAD_BEEF, m1_wb_dat_o=0.
REQ-018 Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): GNT0, no ack -> m0_wb_err_o single pulse 8 cycles after stb; without macro no err after 100 cycles.
REQ-019 Reset mid-transfer: rst_n low during GNT1 stall -> all outputs 0 same cycle; after release, m0 and m1 requesting -> GNT0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin on contention, grant held for the whole cycle.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        m0_wb_cyc_i,
    input  logic        m0_wb_stb_i,
    input  logic        m0_wb_we_i,
    input  logic [3:0]  m0_wb_sel_i,
    input  logic [31:0] m0_wb_adr_i,
    input  logic [31:0] m0_wb_dat_i,
    output logic [31:0] m0_wb_dat_o,
    output logic        m0_wb_ack_o,
    output logic        m0_wb_err_o,
    input  logic        m1_wb_cyc_i,
    input  logic        m1_wb_stb_i,
    input  logic        m1_wb_we_i,
    input  logic [3:0]  m1_wb_sel_i,
    input  logic [31:0] m1_wb_adr_i,
    input  logic [31:0] m1_wb_dat_i,
    output logic [31:0] m1_wb_dat_o,
    output logic        m1_wb_ack_o,
    output logic        m1_wb_err_o,
    output logic        s_wb_cyc_o,
    output logic        s_wb_stb_o,
    output logic        s_wb_we_o,
    output logic [3:0]  s_wb_sel_o,
    output logic [31:0] s_wb_adr_o,
    output logic [31:0] s_wb_dat_o,
    input  logic [31:0] s_wb_dat_i,
    input  logic        s_wb_ack_i,
    input  logic        s_wb_err_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   granted, sel_m1, own_cyc, own_stb, to_hit;

    assign granted = (state_q != IDLE);
    assign sel_m1  = (state_q == GNT1);
    assign own_cyc = sel_m1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    assign own_stb = sel_m1 ? m1_wb_stb_i : m0_wb_stb_i;

    // Next-state: on contention the master that did not own the bus last wins.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d      = last_owner_q ? GNT0 : GNT1;
                    last_owner_d = ~last_owner_q;
                end else if (m0_wb_cyc_i) begin
                    state_d      = GNT0;
                    last_owner_d = 1'b0;
                end else if (m1_wb_cyc_i) begin
                    state_d      = GNT1;
                    last_owner_d = 1'b1;
                end
            end
            GNT0:    if (!m0_wb_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_wb_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts stalled strobe cycles; any ack/err or leaving the grant restarts it.
    always_comb begin
        cnt_d  = '0;
        to_hit = 1'b0;
        if (granted && own_stb && !s_wb_ack_i && !s_wb_err_i) begin
            if (cnt_q == TO_LAST) begin
                to_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = 16'(TIMEOUT_CYC);
`endif

    // Shared-bus mux plus response routing; responses only reach an owner still in its cycle.
    always_comb begin
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_we_o   = 1'b0;
        s_wb_sel_o  = '0;
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        m0_wb_dat_o = '0;
        m0_wb_ack_o = 1'b0;
        m0_wb_err_o = 1'b0;
        m1_wb_dat_o = '0;
        m1_wb_ack_o = 1'b0;
        m1_wb_err_o = 1'b0;
        if (granted) begin
            s_wb_cyc_o = own_cyc;
            s_wb_stb_o = own_stb && !to_hit;
            s_wb_we_o  = sel_m1 ? m1_wb_we_i  : m0_wb_we_i;
            s_wb_sel_o = sel_m1 ? m1_wb_sel_i : m0_wb_sel_i;
            s_wb_adr_o = sel_m1 ? m1_wb_adr_i : m0_wb_adr_i;
            s_wb_dat_o = sel_m1 ? m1_wb_dat_i : m0_wb_dat_i;
            if (sel_m1) begin
                m1_wb_dat_o = s_wb_dat_i;
                m1_wb_ack_o = own_cyc && s_wb_ack_i;
                m1_wb_err_o = own_cyc && (s_wb_err_i || to_hit);
            end else begin
                m0_wb_dat_o = s_wb_dat_i;
                m0_wb_ack_o = own_cyc && s_wb_ack_i;
                m0_wb_err_o = own_cyc && (s_wb_err_i || to_hit);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table for routing/grant plus hand sequences
// for alternation, watchdog behaviour and reset mid-transfer.
module tb_wb_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] W0 = 32'h1111_1111;
    localparam logic [31:0] A1 = 32'h0000_1004;
    localparam logic [31:0] W1 = 32'hA5A5_0001;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
    logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, s_ack, s_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
        .m0_wb_sel_i(m0_sel), .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat),
        .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
        .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
        .m1_wb_sel_i(m1_sel), .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat),
        .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_sel_o(s_sel), .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat),
        .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err)
    );

    typedef struct {
        logic        c0, c1, ack;
        logic [31:0] rdat;
        logic        scyc;
        logic [31:0] sadr, sdat;
        logic        a0, a1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [199:0] all_outs();
        return 200'({m0_rdat, m0_ack, m0_err, m1_rdat, m1_ack, m1_err,
                     s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int first_err, err0_cnt, err1_cnt;
        logic err_after, stb_at_hit;

        vecs[0]  = '{0, 0, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0, 32'h0,         32'h0};
        vecs[1]  = '{0, 1, 1, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 0, 0, 32'h0,         32'h0};
        vecs[2]  = '{0, 1, 0, 32'h0,         1, A1,    W1,    0, 0, 32'h0,         32'h0};
        vecs[3]  = '{0, 1, 1, 32'h1234_5678, 1, A1,    W1,    0, 1, 32'h0,         32'h1234_5678};
        vecs[4]  = '{1, 0, 1, 32'h0,         0, A1,    W1,    0, 0, 32'h0,         32'h0};
        vecs[5]  = '{1, 0, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0, 32'h0,         32'h0};
        vecs[6]  = '{1, 0, 1, 32'hDEAD_BEEF, 1, A0,    W0,    1, 0, 32'hDEAD_BEEF, 32'h0};
        vecs[7]  = '{1, 1, 0, 32'h0,         1, A0,    W0,    0, 0, 32'h0,         32'h0};
        vecs[8]  = '{0, 1, 0, 32'h0,         0, A0,    W0,    0, 0, 32'h0,         32'h0};
        vecs[9]  = '{0, 1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0, 32'h0,         32'h0};
        vecs[10] = '{0, 1, 1, 32'hCAFE_F00D, 1, A1,    W1,    0, 1, 32'h0,         32'hCAFE_F00D};
        vecs[11] = '{0, 0, 0, 32'h0,         0, A1,    W1,    0, 0, 32'h0,         32'h0};

        rst_n  = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'hF; m0_adr = A0; m0_wdat = W0;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_sel = 4'h3; m1_adr = A1; m1_wdat = W1;
        s_rdat = '0; s_ack = 0; s_err = 0;
        #2;
        check("reset_outputs", all_outs(), 200'(0));
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            tick();
            m0_cyc = vecs[i].c0; m0_stb = vecs[i].c0;
            m1_cyc = vecs[i].c1; m1_stb = vecs[i].c1;
            s_ack  = vecs[i].ack; s_rdat = vecs[i].rdat;
            #4;
            check($sformatf("vec%0d", i),
                  200'({s_cyc, s_stb, s_adr, s_wdat, m0_ack, m1_ack, m0_rdat, m1_rdat}),
                  200'({vecs[i].scyc, vecs[i].scyc, vecs[i].sadr, vecs[i].sdat,
                        vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1}));
        end
        s_ack = 0; s_rdat = '0;

        // Contention alternation: both request from IDLE each round.
        tick();
        for (int r = 0; r < 8; r++) begin
            tick();
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            tick();
            #4;
            check($sformatf("alt_round%0d", r), 200'({s_cyc, s_adr}),
                  200'({1'b1, (r % 2 == 0) ? A0 : A1}));
            tick();
            m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            tick();
        end

        // Stalled m0 transfer: watchdog pulse (if built in) or silence.
        tick();
        m0_cyc = 1; m0_stb = 1;
        first_err = -1; err0_cnt = 0; err1_cnt = 0; err_after = 0; stb_at_hit = 1;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) tick();
            #4;
            if (m0_err) begin
                err0_cnt++;
                if (first_err < 0) begin
                    first_err  = i;
                    stb_at_hit = s_stb;
                end
            end
            if (m1_err) err1_cnt++;
            if (i == 9) err_after = m0_err;
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("timeout_first_pulse", 200'(first_err), 200'(8));
        check("timeout_single_pulse", 200'(err_after), 200'(0));
        check("timeout_stb_forced", 200'(stb_at_hit), 200'(0));
`else
        check("no_timeout_err", 200'(err0_cnt), 200'(0));
`endif
        check("no_err_to_m1", 200'(err1_cnt), 200'(0));
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        tick();

        // Error routing during a GNT1 stall, then reset mid-transfer.
        m1_cyc = 1; m1_stb = 1;
        tick();
        #4;
        check("gnt1_stall", 200'({s_cyc, s_adr}), 200'({1'b1, A1}));
        s_err = 1;
        #1;
        check("err_route_m1", 200'({m1_err, m0_err}), 200'({1'b1, 1'b0}));
        s_err = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        check("reset_mid_xfer", all_outs(), 200'(0));
        m0_cyc = 1; m0_stb = 1;
        tick();
        rst_n = 1;
        #2;
        check("no_resume", 200'(s_cyc), 200'(0));
        tick();
        #4;
        check("post_reset_gnt0", 200'({s_cyc, s_adr}), 200'({1'b1, A0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
